match_controller: RTL and testbench
===================================

# match_controller

Parametrised match sequencer that succeeds the fixed 20-ball/5-wicket score comparator. It consumes per-delivery scoring events, keeps both teams' innings counters, and sequences the inning 1 → inning 2 → optional super over → result flow. It resolves the winner, including ties, and drives the display/LED logic with the batting-side score, target, runs needed and balls left.

## Interface
Parameters:
- RUN_W, 8, run counter width; all run values saturate at 2^RUN_W-1
- WKT_W, 4, wicket counter width
- BALL_W, 8, ball counter width
- MAX_BALLS, 20, legal balls per main inning
- MAX_WKTS, 5, wickets that end a main inning
- TIE_MODE, 0, tie handling: 0 declares a tie, 1 plays a super over
- SO_BALLS, 6, legal balls per super-over inning
- SO_WKTS, 2, wickets that end a super-over inning

Ports:
- clk_fpga  in  1  clock
- reset  in  1  synchronous, active-high
- delivery_valid  in  1  one delivery this cycle
- delivery_runs  in  3  runs scored off the bat (0–7)
- delivery_wicket  in  1  wicket fell on this delivery
- delivery_extra  in  1  wide/no-ball: +1 run, ball not counted
- next_inning  in  1  pulse; leaves BREAK
- state  out  3  current FSM state
- batting_team  out  1  0 = team 1, 1 = team 2
- inning_over  out  1  one-cycle pulse at every inning end
- game_over  out  1  level, high in DONE
- winner  out  2  00 none, 01 team 1, 10 team 2, 11 tie
- bat_runs / bat_wkts / bat_balls  out  RUN_W / WKT_W / BALL_W  current inning counters
- target  out  RUN_W  runs the chasing side needs to win; 0 in the first inning of a pair
- runs_needed  out  RUN_W  target − bat_runs, floored at 0; 0 when target = 0
- balls_left  out  BALL_W  current limit − bat_balls

## Operation
- States:
  - INN1: team 1 bats.
  - BREAK: waits for next_inning.
  - INN2: team 2 chases.
  - SO1: team 2 bats first in the super over.
  - SO2: team 1 chases.
  - DONE: result is final.
- The FSM holds a registered resume target. BREAK → resume target on next_inning. next_inning in any other state is ignored.
- Deliveries are accepted only in INN1, INN2, SO1 and SO2. They are ignored in BREAK and DONE.
- Accepted delivery updates:
  - runs += delivery_runs + delivery_extra (saturating).
  - wkts += delivery_wicket (saturating at MAX).
  - balls += 1 only when delivery_extra = 0.
- An inning ends when, after the update, wkts ≥ limit_w, balls ≥ limit_b, or (chasing and runs ≥ target).
  - Main innings: limit_w/limit_b = MAX_WKTS/MAX_BALLS.
  - Super-over innings: SO_WKTS/SO_BALLS.
- Actions at an inning end:
  - INN1 end: latch team-1 runs; target = team-1 runs + 1 (saturating); counters clear; → BREAK (resume INN2).
  - INN2 end: compare team-2 runs to team-1 runs.
    - Greater → winner 10.
    - Less → winner 01.
    - Equal and TIE_MODE = 0 → winner 11.
    - Equal and TIE_MODE = 1 → BREAK (resume SO1); counters clear; target = 0.
    - Otherwise → DONE.
  - SO1 end: target = SO1 runs + 1; → BREAK (resume SO2).
  - SO2 end: compare SO2 runs to SO1 runs using the same mapping (SO2 side is team 1); a tie gives 11; → DONE.
- batting_team:
  - 0 in INN1 and SO2.
  - 1 in INN2 and SO1.
  - In BREAK it shows the team that bats next.
- A chase ends on the winning delivery. Remaining balls are not played.

## Timing
- Reset values:
  - state = INN1, batting_team = 0.
  - All counters, target, runs_needed and winner = 0.
  - inning_over = 0, game_over = 0.
  - balls_left = MAX_BALLS.
- Reset mid-match aborts at the next edge, with no result latched.
- A delivery sampled at edge N appears in the counters after edge N.
- An inning end computed from a delivery at edge N has these effects, all after edge N:
  - State changes and inning_over pulses for one cycle.
  - The counters clear.
  - winner and game_over become valid.
  - The final score of that inning stays visible only through the latched values (team-1 runs/target).
- next_inning sampled in BREAK at edge N puts the new state in effect after N. A delivery in that same cycle is ignored.
- winner holds until reset.
- Derived outputs (runs_needed, balls_left, target mux) are combinational from registers. No added latency.

## Structure
- match_pkg holds:
  - the state enum (INN1, BREAK, INN2, SO1, SO2, DONE);
  - winner codes WIN_NONE/WIN_T1/WIN_T2/WIN_TIE;
  - TIE_MODE encodings.
- Sub-module innings_counter holds the saturating runs/wkts/balls registers, with clear and limit inputs and an end-of-inning flag output. One instance is reused across all innings. match_controller contains the FSM, the latched first-inning score, and the comparison logic.

## Test plan
- Defaults, team 1 bats 20 legal 1-run balls → inning_over pulse, target = 21, state BREAK. next_inning → INN2, balls_left = 20.
- INN2 chase: team 2 reaches 21 on its 10th ball → DONE, winner = 10, balls_left is not consumed further. Later deliveries leave every output unchanged.
- Wickets: team 1 loses 5 wickets in 7 balls scoring 12 → INN1 ends, target = 13. Team 2 all out for 12, TIE_MODE = 0 → winner = 11.
- TIE_MODE = 1 with 12–12 → BREAK then SO1.
  - SO1: 8 runs in 6 balls → target = 9.
  - SO2: 9 runs → winner = 01.
  - Repeat the flow with SO2 scoring 8 → winner = 11.
- Extras: wide with delivery_runs = 0 → runs +1, balls unchanged. Run saturation: RUN_W = 3 with 10 runs scored → bat_runs = 7.
- Reset asserted in INN2, and a delivery_valid coincident with next_inning → all outputs return to reset values after the next edge. The coincident delivery is dropped.

Source files
------------

// File: rtl/match_pkg.sv
// Shared types and codes for the match sequencer: FSM states, winner codes
// and tie-handling selections.
package match_pkg;

    typedef enum logic [2:0] {
        INN1  = 3'd0,
        BREAK = 3'd1,
        INN2  = 3'd2,
        SO1   = 3'd3,
        SO2   = 3'd4,
        DONE  = 3'd5
    } match_state_e;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_T1   = 2'b01;
    localparam logic [1:0] WIN_T2   = 2'b10;
    localparam logic [1:0] WIN_TIE  = 2'b11;

    localparam int unsigned TIE_DECLARE    = 0;
    localparam int unsigned TIE_SUPER_OVER = 1;

    // States in which deliveries are scored
    function automatic logic is_batting(match_state_e s);
        return (s == INN1) || (s == INN2) || (s == SO1) || (s == SO2);
    endfunction

endpackage

// File: rtl/innings_counter.sv
// Saturating runs/wickets/balls counters for one inning, reused for every
// inning; flags the delivery that ends the inning from post-update values.
module innings_counter #(
    parameter int unsigned RUN_W  = 8,
    parameter int unsigned WKT_W  = 4,
    parameter int unsigned BALL_W = 8
) (
    input  logic              clk_fpga,
    input  logic              reset,
    input  logic              clear,
    input  logic              accept,
    input  logic [2:0]        runs_in,
    input  logic              wicket_in,
    input  logic              extra_in,
    input  logic              chasing,
    input  logic [RUN_W-1:0]  target,
    input  logic [WKT_W-1:0]  limit_w,
    input  logic [BALL_W-1:0] limit_b,
    output logic [RUN_W-1:0]  run_cnt,
    output logic [WKT_W-1:0]  wkt_cnt,
    output logic [BALL_W-1:0] ball_cnt,
    output logic [RUN_W-1:0]  runs_upd_c,
    output logic              end_c
);

    localparam int unsigned SUM_W = RUN_W + 4;
    localparam logic [RUN_W-1:0]  RUN_MAX  = '1;
    localparam logic [WKT_W-1:0]  WKT_MAX  = '1;
    localparam logic [BALL_W-1:0] BALL_MAX = '1;

    logic [RUN_W-1:0]  runs_q, runs_d;
    logic [WKT_W-1:0]  wkts_q, wkts_d, wkts_upd;
    logic [BALL_W-1:0] balls_q, balls_d, balls_upd;
    logic [SUM_W-1:0]  run_sum;

    // Post-delivery values and end-of-inning detection
    always_comb begin
        run_sum    = SUM_W'(runs_q) + SUM_W'(runs_in) + SUM_W'(extra_in);
        runs_upd_c = (run_sum > SUM_W'(RUN_MAX)) ? RUN_MAX : run_sum[RUN_W-1:0];
        wkts_upd   = (wicket_in && (wkts_q != WKT_MAX)) ? wkts_q + WKT_W'(1) : wkts_q;
        balls_upd  = (!extra_in && (balls_q != BALL_MAX)) ? balls_q + BALL_W'(1) : balls_q;
        end_c      = accept && ((wkts_upd >= limit_w) || (balls_upd >= limit_b) ||
                                (chasing && (runs_upd_c >= target)));
    end

    always_comb begin
        runs_d  = runs_q;
        wkts_d  = wkts_q;
        balls_d = balls_q;
        if (clear) begin
            runs_d  = '0;
            wkts_d  = '0;
            balls_d = '0;
        end else if (accept) begin
            runs_d  = runs_upd_c;
            wkts_d  = wkts_upd;
            balls_d = balls_upd;
        end
    end

    always_ff @(posedge clk_fpga) begin
        if (reset) begin
            runs_q  <= '0;
            wkts_q  <= '0;
            balls_q <= '0;
        end else begin
            runs_q  <= runs_d;
            wkts_q  <= wkts_d;
            balls_q <= balls_d;
        end
    end

    assign run_cnt  = runs_q;
    assign wkt_cnt  = wkts_q;
    assign ball_cnt = balls_q;

endmodule

// File: rtl/match_controller.sv
// Match sequencer: innings 1 and 2, optional super over, result resolution
// and the batting-side display values.
module match_controller
    import match_pkg::*;
#(
    parameter int unsigned RUN_W     = 8,
    parameter int unsigned WKT_W     = 4,
    parameter int unsigned BALL_W    = 8,
    parameter int unsigned MAX_BALLS = 20,
    parameter int unsigned MAX_WKTS  = 5,
    parameter int unsigned TIE_MODE  = 0,
    parameter int unsigned SO_BALLS  = 6,
    parameter int unsigned SO_WKTS   = 2
) (
    input  logic              clk_fpga,
    input  logic              reset,
    input  logic              delivery_valid,
    input  logic [2:0]        delivery_runs,
    input  logic              delivery_wicket,
    input  logic              delivery_extra,
    input  logic              next_inning,
    output logic [2:0]        state,
    output logic              batting_team,
    output logic              inning_over,
    output logic              game_over,
    output logic [1:0]        winner,
    output logic [RUN_W-1:0]  bat_runs,
    output logic [WKT_W-1:0]  bat_wkts,
    output logic [BALL_W-1:0] bat_balls,
    output logic [RUN_W-1:0]  target,
    output logic [RUN_W-1:0]  runs_needed,
    output logic [BALL_W-1:0] balls_left
);

    localparam logic [RUN_W-1:0] RUN_MAX = '1;

    match_state_e state_q, state_d;
    match_state_e resume_q, resume_d;

    logic [RUN_W-1:0] first_runs_q, first_runs_d;
    logic [RUN_W-1:0] target_q, target_d;
    logic [1:0]       winner_q, winner_d;
    logic             inning_over_q, inning_over_d;
    logic             game_over_q, game_over_d;
    logic             batting_team_q, batting_team_d;

    logic              accept_c, chasing_c, super_c, inn_end_c;
    logic              score_gt_c, score_lt_c;
    logic [WKT_W-1:0]  limit_w_c;
    logic [BALL_W-1:0] limit_b_c;
    logic [RUN_W-1:0]  cnt_runs, runs_upd_c;
    logic [WKT_W-1:0]  cnt_wkts;
    logic [BALL_W-1:0] cnt_balls;

    // Limits follow the inning being played, or the one BREAK leads into
    always_comb begin
        accept_c   = delivery_valid && is_batting(state_q);
        chasing_c  = (state_q == INN2) || (state_q == SO2);
        super_c    = (state_q == SO1) || (state_q == SO2) ||
                     ((state_q == BREAK) && ((resume_q == SO1) || (resume_q == SO2)));
        limit_w_c  = super_c ? WKT_W'(SO_WKTS)   : WKT_W'(MAX_WKTS);
        limit_b_c  = super_c ? BALL_W'(SO_BALLS) : BALL_W'(MAX_BALLS);
        score_gt_c = runs_upd_c > first_runs_q;
        score_lt_c = runs_upd_c < first_runs_q;
    end

    innings_counter #(
        .RUN_W  (RUN_W),
        .WKT_W  (WKT_W),
        .BALL_W (BALL_W)
    ) u_innings_counter (
        .clk_fpga   (clk_fpga),
        .reset      (reset),
        .clear      (inn_end_c),
        .accept     (accept_c),
        .runs_in    (delivery_runs),
        .wicket_in  (delivery_wicket),
        .extra_in   (delivery_extra),
        .chasing    (chasing_c),
        .target     (target_q),
        .limit_w    (limit_w_c),
        .limit_b    (limit_b_c),
        .run_cnt    (cnt_runs),
        .wkt_cnt    (cnt_wkts),
        .ball_cnt   (cnt_balls),
        .runs_upd_c (runs_upd_c),
        .end_c      (inn_end_c)
    );

    always_ff @(posedge clk_fpga) begin
        if (reset) begin
            state_q  <= INN1;
            resume_q <= INN2;
        end else begin
            state_q  <= state_d;
            resume_q <= resume_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        resume_d = resume_q;
        case (state_q)
            INN1: begin
                if (inn_end_c) begin
                    state_d  = BREAK;
                    resume_d = INN2;
                end
            end
            BREAK: begin
                if (next_inning) state_d = resume_q;
            end
            INN2: begin
                if (inn_end_c) begin
                    if (!score_gt_c && !score_lt_c && (TIE_MODE == TIE_SUPER_OVER)) begin
                        state_d  = BREAK;
                        resume_d = SO1;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            SO1: begin
                if (inn_end_c) begin
                    state_d  = BREAK;
                    resume_d = SO2;
                end
            end
            SO2: begin
                if (inn_end_c) state_d = DONE;
            end
            DONE: ;
            default: state_d = INN1;
        endcase
    end

    // Latched scores, target and result, registered alongside the state
    always_comb begin
        first_runs_d   = first_runs_q;
        target_d       = target_q;
        winner_d       = winner_q;
        inning_over_d  = inn_end_c;
        game_over_d    = (state_d == DONE);
        batting_team_d = batting_team_q;

        case (state_d)
            INN1, SO2: batting_team_d = 1'b0;
            INN2, SO1: batting_team_d = 1'b1;
            BREAK:     batting_team_d = (resume_d == INN2) || (resume_d == SO1);
            default:   batting_team_d = batting_team_q;
        endcase

        if (inn_end_c) begin
            case (state_q)
                INN1, SO1: begin
                    first_runs_d = runs_upd_c;
                    target_d     = (runs_upd_c == RUN_MAX) ? RUN_MAX : runs_upd_c + RUN_W'(1);
                end
                INN2: begin
                    if (score_gt_c)                   winner_d = WIN_T2;
                    else if (score_lt_c)              winner_d = WIN_T1;
                    else if (TIE_MODE == TIE_DECLARE) winner_d = WIN_TIE;
                    else                              target_d = '0;
                end
                SO2: begin
                    if (score_gt_c)      winner_d = WIN_T1;
                    else if (score_lt_c) winner_d = WIN_T2;
                    else                 winner_d = WIN_TIE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_fpga) begin
        if (reset) begin
            first_runs_q   <= '0;
            target_q       <= '0;
            winner_q       <= WIN_NONE;
            inning_over_q  <= 1'b0;
            game_over_q    <= 1'b0;
            batting_team_q <= 1'b0;
        end else begin
            first_runs_q   <= first_runs_d;
            target_q       <= target_d;
            winner_q       <= winner_d;
            inning_over_q  <= inning_over_d;
            game_over_q    <= game_over_d;
            batting_team_q <= batting_team_d;
        end
    end

    assign state        = state_q;
    assign batting_team = batting_team_q;
    assign inning_over  = inning_over_q;
    assign game_over    = game_over_q;
    assign winner       = winner_q;
    assign bat_runs     = cnt_runs;
    assign bat_wkts     = cnt_wkts;
    assign bat_balls    = cnt_balls;
    assign target       = target_q;
    assign runs_needed  = ((target_q != '0) && (target_q > cnt_runs)) ? target_q - cnt_runs : '0;
    assign balls_left   = limit_b_c - cnt_balls;

endmodule

// File: tb/tb_match_controller.sv
// Three configurations (tie declared, super over, 3-bit runs) share one
// delivery stream and are compared every cycle against a behavioural match model.
module tb_match_controller;
    import match_pkg::*;

    logic clk_fpga = 1'b0;
    always #5 clk_fpga = ~clk_fpga;

    logic       reset = 1'b1;
    logic       delivery_valid = 1'b0;
    logic [2:0] delivery_runs = 3'd0;
    logic       delivery_wicket = 1'b0;
    logic       delivery_extra = 1'b0;
    logic       next_inning = 1'b0;

    logic [2:0] o0_state, o1_state, o2_state;
    logic       o0_batting_team, o1_batting_team, o2_batting_team;
    logic       o0_inning_over, o1_inning_over, o2_inning_over;
    logic       o0_game_over, o1_game_over, o2_game_over;
    logic [1:0] o0_winner, o1_winner, o2_winner;
    logic [7:0] o0_bat_runs, o1_bat_runs;
    logic [2:0] o2_bat_runs;
    logic [3:0] o0_bat_wkts, o1_bat_wkts, o2_bat_wkts;
    logic [7:0] o0_bat_balls, o1_bat_balls, o2_bat_balls;
    logic [7:0] o0_target, o1_target;
    logic [2:0] o2_target;
    logic [7:0] o0_runs_needed, o1_runs_needed;
    logic [2:0] o2_runs_needed;
    logic [7:0] o0_balls_left, o1_balls_left, o2_balls_left;

    match_controller #(.TIE_MODE(TIE_DECLARE)) dut0 (
        .clk_fpga(clk_fpga), .reset(reset), .delivery_valid(delivery_valid),
        .delivery_runs(delivery_runs), .delivery_wicket(delivery_wicket),
        .delivery_extra(delivery_extra), .next_inning(next_inning),
        .state(o0_state), .batting_team(o0_batting_team), .inning_over(o0_inning_over),
        .game_over(o0_game_over), .winner(o0_winner), .bat_runs(o0_bat_runs),
        .bat_wkts(o0_bat_wkts), .bat_balls(o0_bat_balls), .target(o0_target),
        .runs_needed(o0_runs_needed), .balls_left(o0_balls_left));

    match_controller #(.TIE_MODE(TIE_SUPER_OVER)) dut1 (
        .clk_fpga(clk_fpga), .reset(reset), .delivery_valid(delivery_valid),
        .delivery_runs(delivery_runs), .delivery_wicket(delivery_wicket),
        .delivery_extra(delivery_extra), .next_inning(next_inning),
        .state(o1_state), .batting_team(o1_batting_team), .inning_over(o1_inning_over),
        .game_over(o1_game_over), .winner(o1_winner), .bat_runs(o1_bat_runs),
        .bat_wkts(o1_bat_wkts), .bat_balls(o1_bat_balls), .target(o1_target),
        .runs_needed(o1_runs_needed), .balls_left(o1_balls_left));

    match_controller #(.RUN_W(3), .TIE_MODE(TIE_DECLARE)) dut2 (
        .clk_fpga(clk_fpga), .reset(reset), .delivery_valid(delivery_valid),
        .delivery_runs(delivery_runs), .delivery_wicket(delivery_wicket),
        .delivery_extra(delivery_extra), .next_inning(next_inning),
        .state(o2_state), .batting_team(o2_batting_team), .inning_over(o2_inning_over),
        .game_over(o2_game_over), .winner(o2_winner), .bat_runs(o2_bat_runs),
        .bat_wkts(o2_bat_wkts), .bat_balls(o2_bat_balls), .target(o2_target),
        .runs_needed(o2_runs_needed), .balls_left(o2_balls_left));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural match model, one slot per DUT configuration
    int c_rmax [3] = '{255, 255, 7};
    bit c_tie  [3] = '{1'b0, 1'b1, 1'b0};
    int m_state [3], m_resume [3], m_runs [3], m_wkts [3], m_balls [3];
    int m_first [3], m_target [3], m_winner [3];
    bit m_iover [3];

    function automatic int min2(int a, int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_step(input int i, input bit rst, input bit v, input int r,
                              input bit w, input bit e, input bit nx);
        int  lw, lb, score;
        bit  sup, chase;
        m_iover[i] = 1'b0;
        if (rst) begin
            m_state[i] = int'(INN1); m_resume[i] = int'(INN2);
            m_runs[i] = 0; m_wkts[i] = 0; m_balls[i] = 0;
            m_first[i] = 0; m_target[i] = 0; m_winner[i] = 0;
        end else if (m_state[i] == int'(BREAK)) begin
            if (nx) m_state[i] = m_resume[i];
        end else if (v && m_state[i] != int'(DONE)) begin
            m_runs[i]  = min2(m_runs[i] + r + int'(e), c_rmax[i]);
            m_wkts[i]  = m_wkts[i] + int'(w);
            m_balls[i] = m_balls[i] + (e ? 0 : 1);
            sup   = (m_state[i] == int'(SO1)) || (m_state[i] == int'(SO2));
            chase = (m_state[i] == int'(INN2)) || (m_state[i] == int'(SO2));
            lw = sup ? 2 : 5;
            lb = sup ? 6 : 20;
            if (m_wkts[i] >= lw || m_balls[i] >= lb || (chase && m_runs[i] >= m_target[i])) begin
                m_iover[i] = 1'b1;
                score = m_runs[i];
                m_runs[i] = 0; m_wkts[i] = 0; m_balls[i] = 0;
                if (m_state[i] == int'(INN1) || m_state[i] == int'(SO1)) begin
                    m_resume[i] = (m_state[i] == int'(INN1)) ? int'(INN2) : int'(SO2);
                    m_first[i]  = score;
                    m_target[i] = min2(score + 1, c_rmax[i]);
                    m_state[i]  = int'(BREAK);
                end else if (m_state[i] == int'(INN2)) begin
                    if (score == m_first[i] && c_tie[i]) begin
                        m_state[i] = int'(BREAK); m_resume[i] = int'(SO1); m_target[i] = 0;
                    end else begin
                        m_winner[i] = (score > m_first[i]) ? 2 : (score < m_first[i]) ? 1 : 3;
                        m_state[i]  = int'(DONE);
                    end
                end else begin
                    m_winner[i] = (score > m_first[i]) ? 1 : (score < m_first[i]) ? 2 : 3;
                    m_state[i]  = int'(DONE);
                end
            end
        end
    endtask

    task automatic check_dut(input int i);
        int obs [11];
        int exp_bat, exp_need, lim;
        bit sup;
        case (i)
            0: obs = '{int'(o0_state), int'(o0_batting_team), int'(o0_inning_over), int'(o0_game_over),
                       int'(o0_winner), int'(o0_bat_runs), int'(o0_bat_wkts), int'(o0_bat_balls),
                       int'(o0_target), int'(o0_runs_needed), int'(o0_balls_left)};
            1: obs = '{int'(o1_state), int'(o1_batting_team), int'(o1_inning_over), int'(o1_game_over),
                       int'(o1_winner), int'(o1_bat_runs), int'(o1_bat_wkts), int'(o1_bat_balls),
                       int'(o1_target), int'(o1_runs_needed), int'(o1_balls_left)};
            default: obs = '{int'(o2_state), int'(o2_batting_team), int'(o2_inning_over), int'(o2_game_over),
                       int'(o2_winner), int'(o2_bat_runs), int'(o2_bat_wkts), int'(o2_bat_balls),
                       int'(o2_target), int'(o2_runs_needed), int'(o2_balls_left)};
        endcase
        exp_bat = (m_state[i] == int'(INN2) || m_state[i] == int'(SO1) ||
                   (m_state[i] == int'(BREAK) && (m_resume[i] == int'(INN2) || m_resume[i] == int'(SO1)))) ? 1 : 0;
        exp_need = (m_target[i] > m_runs[i]) ? m_target[i] - m_runs[i] : 0;
        sup = (m_state[i] == int'(SO1)) || (m_state[i] == int'(SO2)) ||
              (m_state[i] == int'(BREAK) && (m_resume[i] == int'(SO1) || m_resume[i] == int'(SO2)));
        lim = sup ? 6 : 20;
        check_val($sformatf("d%0d.state", i), obs[0], m_state[i]);
        if (m_state[i] != int'(DONE)) begin
            check_val($sformatf("d%0d.batting_team", i), obs[1], exp_bat);
            check_val($sformatf("d%0d.balls_left", i), obs[10], lim - m_balls[i]);
        end
        check_val($sformatf("d%0d.inning_over", i), obs[2], int'(m_iover[i]));
        check_val($sformatf("d%0d.game_over", i), obs[3], (m_state[i] == int'(DONE)) ? 1 : 0);
        check_val($sformatf("d%0d.winner", i), obs[4], m_winner[i]);
        check_val($sformatf("d%0d.bat_runs", i), obs[5], m_runs[i]);
        check_val($sformatf("d%0d.bat_wkts", i), obs[6], m_wkts[i]);
        check_val($sformatf("d%0d.bat_balls", i), obs[7], m_balls[i]);
        check_val($sformatf("d%0d.target", i), obs[8], m_target[i]);
        check_val($sformatf("d%0d.runs_needed", i), obs[9], exp_need);
    endtask

    task automatic cycle(input bit rst, input bit v, input int r, input bit w,
                         input bit e, input bit nx);
        reset           = rst;
        delivery_valid  = v;
        delivery_runs   = 3'(r);
        delivery_wicket = w;
        delivery_extra  = e;
        next_inning     = nx;
        @(posedge clk_fpga);
        for (int i = 0; i < 3; i++) model_step(i, rst, v, r, w, e, nx);
        #1;
        for (int i = 0; i < 3; i++) check_dut(i);
    endtask

    task automatic bowl(input int r, input bit w, input bit e);
        cycle(1'b0, 1'b1, r, w, e, 1'b0);
    endtask

    task automatic do_next();
        cycle(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    int wk_runs [7] = '{2, 0, 4, 1, 3, 0, 2};
    bit wk_wkt  [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    int so1_runs [6] = '{1, 2, 1, 0, 2, 2};
    int so2_tie  [6] = '{1, 1, 1, 1, 2, 2};

    task automatic tied_main_innings();
        for (int k = 0; k < 7; k++) bowl(wk_runs[k], wk_wkt[k], 1'b0);
        check_val("wkt_inn1_target", int'(o0_target), 13);
        do_next();
        for (int k = 0; k < 7; k++) bowl(wk_runs[k], wk_wkt[k], 1'b0);
    endtask

    initial begin
        do_reset();
        do_reset();
        check_val("reset_state", int'(o0_state), int'(INN1));
        check_val("reset_balls_left", int'(o0_balls_left), 20);

        // Team 1 scores 20 singles; team 2 chases 21 on the 10th ball
        for (int k = 0; k < 20; k++) bowl(1, 1'b0, 1'b0);
        check_val("inn1_pulse", int'(o0_inning_over), 1);
        check_val("inn1_target", int'(o0_target), 21);
        check_val("inn1_break", int'(o0_state), int'(BREAK));
        cycle(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        do_next();
        check_val("inn2_balls_left", int'(o0_balls_left), 20);
        for (int k = 0; k < 9; k++) bowl(2, 1'b0, 1'b0);
        bowl(3, 1'b0, 1'b0);
        check_val("chase_winner", int'(o0_winner), 2);
        check_val("chase_done", int'(o0_state), int'(DONE));
        for (int k = 0; k < 3; k++) bowl(4, 1'b1, 1'b0);
        do_next();

        // Wickets and a tie: declared on dut0, super over on dut1
        do_reset();
        tied_main_innings();
        check_val("tie_declared", int'(o0_winner), 3);
        check_val("tie_so_break", int'(o1_state), int'(BREAK));
        do_next();
        check_val("so1_entered", int'(o1_state), int'(SO1));
        for (int k = 0; k < 6; k++) bowl(so1_runs[k], 1'b0, 1'b0);
        check_val("so1_target", int'(o1_target), 9);
        do_next();
        bowl(4, 1'b0, 1'b0); bowl(4, 1'b0, 1'b0); bowl(1, 1'b0, 1'b0);
        check_val("so2_t1_wins", int'(o1_winner), 1);

        do_reset();
        tied_main_innings();
        do_next();
        for (int k = 0; k < 6; k++) bowl(so1_runs[k], 1'b0, 1'b0);
        do_next();
        for (int k = 0; k < 6; k++) bowl(so2_tie[k], 1'b0, 1'b0);
        check_val("so2_tie", int'(o1_winner), 3);

        // Extras and run saturation
        do_reset();
        bowl(0, 1'b0, 1'b1);
        check_val("wide_runs", int'(o0_bat_runs), 1);
        check_val("wide_balls", int'(o0_bat_balls), 0);
        bowl(5, 1'b0, 1'b0);
        bowl(5, 1'b0, 1'b0);
        check_val("sat_runs", int'(o2_bat_runs), 7);

        // Delivery coincident with next_inning, then reset mid-chase
        do_reset();
        for (int k = 0; k < 20; k++) bowl(1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 6, 1'b0, 1'b0, 1'b1);
        check_val("coincident_drop", int'(o0_bat_runs), 0);
        bowl(2, 1'b0, 1'b0);
        bowl(2, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 3, 1'b0, 1'b0, 1'b0);
        check_val("abort_state", int'(o0_state), int'(INN1));
        check_val("abort_target", int'(o0_target), 0);
        check_val("abort_winner", int'(o0_winner), 0);

        // Randomized matches
        for (int n = 0; n < 4000; n++) begin
            bit rst, v, w, e, nx;
            int r;
            rst = ($urandom_range(0, 299) == 0) ||
                  (m_state[0] == int'(DONE) && m_state[1] == int'(DONE) && $urandom_range(0, 9) == 0);
            nx  = ($urandom_range(0, 5) == 0);
            v   = ($urandom_range(0, 3) != 0);
            r   = ($urandom_range(0, 9) < 6) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 7));
            w   = ($urandom_range(0, 7) == 0);
            e   = ($urandom_range(0, 9) == 0);
            cycle(rst, v, r, w, e, nx);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
